// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I types and constants for the write-back stage
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_MEM  = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// rtl/mem_wb_stage_load_extend.sv - load byte/half extraction with sign/zero extension
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (off)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        // halfword accesses are taken as aligned; off[0] is ignored
        half_sel = off[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        ext = raw;
        case (funct3)
            F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register, result select and retired-instruction counter
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_m,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       funct3M,
    input  logic [4:0]       RdM,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    output logic [4:0]       A3,
    output logic [XLEN-1:0]  WD3,
    output logic             WE3,
    output logic             RegWriteW,
    output logic             valid_w,
    output logic [CNT_W-1:0] instret
);

    logic              valid_q,      valid_d;
    logic              reg_write_q,  reg_write_d;
    result_src_e       result_src_q, result_src_d;
    logic [2:0]        funct3_q,     funct3_d;
    logic [4:0]        rd_q,         rd_d;
    logic [XLEN-1:0]   alu_result_q, alu_result_d;
    logic [XLEN-1:0]   read_data_q,  read_data_d;
    logic [XLEN-1:0]   pc_plus4_q,   pc_plus4_d;
    logic [CNT_W-1:0]  instret_q,    instret_d;
    logic [XLEN-1:0]   load_ext;

    // flush only kills the valid/write bits; payload is held since it is masked anyway
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        pc_plus4_d   = pc_plus4_q;
        instret_d    = instret_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!stall) begin
            valid_d      = valid_m;
            reg_write_d  = RegWriteM;
            result_src_d = result_src_e'(ResultSrcM);
            funct3_d     = funct3M;
            rd_d         = RdM;
            alu_result_d = ALUResultM;
            read_data_d  = ReadDataM;
            pc_plus4_d   = PCPlus4M;
            if (valid_m) begin
                instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= RES_ALU;
            funct3_q     <= 3'd0;
            rd_q         <= 5'd0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
            instret_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            pc_plus4_q   <= pc_plus4_d;
            instret_q    <= instret_d;
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3 (funct3_q),
        .off    (alu_result_q[1:0]),
        .raw    (read_data_q),
        .ext    (load_ext)
    );

    always_comb begin
        WD3 = '0;
        case (result_src_q)
            RES_ALU: WD3 = alu_result_q;
            RES_MEM: WD3 = load_ext;
            RES_PC4: WD3 = pc_plus4_q;
            default: WD3 = '0;
        endcase
    end

    // x0 is hardwired to zero, so a write to it is dropped here
    assign A3        = rd_q;
    assign RegWriteW = valid_q & reg_write_q;
    assign WE3       = RegWriteW & (rd_q != 5'd0);
    assign valid_w   = valid_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_m = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic [2:0]  funct3M = 3'd0;
    logic [4:0]  RdM = 5'd0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] ReadDataM = '0;
    logic [31:0] PCPlus4M = '0;

    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3, RegWriteW, valid_w;
    logic [31:0] instret;

    logic [4:0]  A3_n;
    logic [31:0] WD3_n;
    logic        WE3_n, RegWriteW_n, valid_w_n;
    logic [3:0]  instret_n;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .A3(A3), .WD3(WD3), .WE3(WE3), .RegWriteW(RegWriteW), .valid_w(valid_w),
        .instret(instret)
    );

    // narrow counter copy so the wrap to zero is reachable in a short run
    mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_m(valid_m),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M), .RdM(RdM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
        .A3(A3_n), .WD3(WD3_n), .WE3(WE3_n), .RegWriteW(RegWriteW_n), .valid_w(valid_w_n),
        .instret(instret_n)
    );

    typedef struct {
        logic        valid;
        logic        rw;
        logic [1:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] e_wd3;
        logic        e_we3;
    } vec_t;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic        we3;
        logic        valid;
        logic        rw;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_instret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic rw, input logic [1:0] src,
                                input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [31:0] e_wd3, input logic e_we3);
        vec_t t;
        t.valid = v; t.rw = rw; t.src = src; t.f3 = f3; t.rd = rd; t.alu = alu;
        t.rdata = 32'h80FF_7F01; t.pc4 = pc4; t.e_wd3 = e_wd3; t.e_we3 = e_we3;
        return t;
    endfunction

    task automatic drive(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        valid_m = v.valid; RegWriteM = v.rw; ResultSrcM = v.src; funct3M = v.f3;
        RdM = v.rd; ALUResultM = v.alu; ReadDataM = v.rdata; PCPlus4M = v.pc4;
        if (v.valid) exp_instret = exp_instret + 32'd1;
        e.a3 = v.rd; e.wd3 = v.e_wd3; e.we3 = v.e_we3; e.valid = v.valid;
        e.rw = v.valid & v.rw; e.instret = exp_instret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".A3"}, {27'd0, A3}, {27'd0, e.a3});
        check({tag, ".WD3"}, WD3, e.wd3);
        check({tag, ".WE3"}, {31'd0, WE3}, {31'd0, e.we3});
        check({tag, ".valid_w"}, {31'd0, valid_w}, {31'd0, e.valid});
        check({tag, ".RegWriteW"}, {31'd0, RegWriteW}, {31'd0, e.rw});
        check({tag, ".instret"}, instret, e.instret);
        check({tag, ".instret_narrow"}, {28'd0, instret_n}, {28'd0, e.instret[3:0]});
    endtask

    task automatic idle_inputs();
        valid_m = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'd0;
        RdM = 5'd0; ALUResultM = '0; ReadDataM = '0; PCPlus4M = '0;
        stall = 1'b0; flush = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.WE3", {31'd0, WE3}, 32'd0);
        check("reset.A3", {27'd0, A3}, 32'd0);
        check("reset.WD3", WD3, 32'd0);
        check("reset.valid_w", {31'd0, valid_w}, 32'd0);
        check("reset.instret", instret, 32'd0);
        rst = 1'b0;

        vecs.push_back(mk(1, 1, RES_ALU, F3_LW,  5'd5,  32'h1234_5678, 32'h0, 32'h1234_5678, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LB,  5'd6,  32'h0000_1003, 32'h0, 32'hFFFF_FF80, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LBU, 5'd7,  32'h0000_2001, 32'h0, 32'h0000_007F, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LH,  5'd8,  32'h0000_2002, 32'h0, 32'hFFFF_80FF, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LHU, 5'd9,  32'h0000_2000, 32'h0, 32'h0000_7F01, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LW,  5'd10, 32'h0000_2001, 32'h0, 32'h80FF_7F01, 1));
        vecs.push_back(mk(1, 1, RES_MEM, 3'b011, 5'd11, 32'h0000_0002, 32'h0, 32'h80FF_7F01, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LH,  5'd12, 32'h0000_0003, 32'h0, 32'hFFFF_80FF, 1));
        vecs.push_back(mk(1, 1, RES_MEM, F3_LBU, 5'd13, 32'h0000_0000, 32'h0, 32'h0000_0001, 1));
        vecs.push_back(mk(1, 1, RES_PC4, F3_LW,  5'd1,  32'h0000_0055, 32'h104, 32'h0000_0104, 1));
        vecs.push_back(mk(1, 1, 2'b11,   F3_LW,  5'd2,  32'h0000_0055, 32'h104, 32'h0000_0000, 1));
        vecs.push_back(mk(1, 1, RES_ALU, F3_LW,  5'd0,  32'h0000_DEAD, 32'h0, 32'h0000_DEAD, 0));
        vecs.push_back(mk(1, 0, RES_ALU, F3_LW,  5'd3,  32'h0000_BEEF, 32'h0, 32'h0000_BEEF, 0));
        vecs.push_back(mk(0, 1, RES_ALU, F3_LW,  5'd4,  32'h0000_CAFE, 32'h0, 32'h0000_CAFE, 0));

        foreach (vecs[i]) drive(vecs[i], $sformatf("vec%0d", i));

        // JAL captured, then held for three stalled edges with different M-stage inputs
        drive(mk(1, 1, RES_PC4, F3_LW, 5'd1, 32'h0, 32'h104, 32'h104, 1), "jal");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1; valid_m = 1'b1; RegWriteM = 1'b1; RdM = 5'd7;
            PCPlus4M = 32'h999; ResultSrcM = RES_ALU; ALUResultM = 32'h777;
            @(posedge clk);
            #1;
            check($sformatf("stall%0d.WD3", k), WD3, 32'h104);
            check($sformatf("stall%0d.A3", k), {27'd0, A3}, 32'd1);
            check($sformatf("stall%0d.WE3", k), {31'd0, WE3}, 32'd1);
            check($sformatf("stall%0d.instret", k), instret, exp_instret);
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush.valid_w", {31'd0, valid_w}, 32'd0);
        check("flush.WE3", {31'd0, WE3}, 32'd0);
        check("flush.RegWriteW", {31'd0, RegWriteW}, 32'd0);
        check("flush.instret", instret, exp_instret);

        // reset asserted mid-cycle while a write is pending
        drive(mk(1, 1, RES_ALU, F3_LW, 5'd9, 32'h0000_4242, 32'h0, 32'h0000_4242, 1), "prerst");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async.WE3", {31'd0, WE3}, 32'd0);
        check("rst_async.valid_w", {31'd0, valid_w}, 32'd0);
        check("rst_async.instret", instret, 32'd0);
        check("rst_async.instret_narrow", {28'd0, instret_n}, 32'd0);
        exp_instret = '0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_rst.WE3", {31'd0, WE3}, 32'd0);
            check("post_rst.A3", {27'd0, A3}, 32'd0);
            check("post_rst.WD3", WD3, 32'd0);
            check("post_rst.instret", instret, 32'd0);
        end

        // sixteen retirements: narrow counter reaches 15 and then wraps to 0
        for (int i = 0; i < 16; i++) begin
            drive(mk(1, 1, RES_ALU, F3_LW, 5'd3, 32'(i), 32'h0, 32'(i), 1), $sformatf("wrap%0d", i));
        end
        check("wrap.narrow_zero", {28'd0, instret_n}, 32'd0);
        check("wrap.wide_16", instret, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
